ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage and IF/ID pipeline register of the 5-stage core. Holds the PC, issues requests to instruction memory over a variable-latency valid handshake, and presents {pc, instruction, valid} to decode. Directly upstream of decode and the hazard unit: it consumes the load-use halt and the data-busy freeze, and takes branch/jump redirects from EX.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction word presented on bubbles (addi x0,x0,0)

- i_clk  in  1  global clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_halt  in  1  load-use stall from hazard unit (hold PC and IF/ID)
- i_data_busy  in  1  data-cache miss; entire pipeline frozen
- i_redirect  in  1  taken branch/jump from EX
- i_redirect_pc  in  32  redirect target
- o_imem_req  out  1  fetch request; o_imem_addr valid while high
- o_imem_addr  out  32  fetch address (current PC)
- i_imem_valid  in  1  i_imem_rdata holds the word for o_imem_addr; may assert in the same cycle as o_imem_req
- i_imem_rdata  in  32  instruction word
- o_id_valid  out  1  IF/ID holds a real instruction
- o_id_pc  out  32  PC of IF/ID instruction
- o_id_inst  out  32  IF/ID instruction
- o_flush  out  1  combinational, = i_redirect & !i_data_busy; drives hazard unit i_flush
- o_misalign  out  1  see Configuration

## Operation
- States: BOOT, FETCH, HOLD, DISCARD.
- stall = i_halt | i_data_busy. Redirect is accepted when i_redirect & !i_data_busy; it overrides i_halt.
- BOOT: o_imem_req=0; next cycle -> FETCH.
- FETCH: o_imem_req=1, o_imem_addr=pc.
  - Redirect accepted: pc<=i_redirect_pc; IF/ID<=bubble; if i_imem_valid this cycle -> FETCH, else -> DISCARD.
  - Else i_imem_valid & !stall: IF/ID<={pc, rdata, 1}; pc<=pc+4 (mod 2^32); stay FETCH.
  - Else i_imem_valid & stall: hold_inst<=rdata; IF/ID unchanged -> HOLD.
  - Else !stall: IF/ID<=bubble. Else: IF/ID unchanged.
- HOLD: o_imem_req=0. Redirect accepted: drop hold, pc<=target, IF/ID<=bubble -> FETCH. Else !stall: IF/ID<={pc, hold_inst, 1}; pc<=pc+4 -> FETCH.
- DISCARD: o_imem_req=1 at the stale address; the returning word is dropped. On i_imem_valid -> FETCH (new pc). Redirect here updates pc and stays DISCARD. IF/ID<=bubble whenever !stall.
- Bubble = {o_id_valid=0, o_id_pc unchanged, o_id_inst=NOP_INST}.
- Under stall without redirect, IF/ID and pc never change.

## Timing
- Reset values: state BOOT, pc=RESET_PC, o_imem_req=0, o_imem_addr=RESET_PC, o_id_valid=0, o_id_pc=RESET_PC, o_id_inst=NOP_INST, o_misalign=0, hold_inst=NOP_INST.
- Zero-wait memory: o_id_valid first rises 2 cycles after reset release. Steady state is 1 instruction per cycle.
- Branch penalty: the target instruction reaches IF/ID no earlier than 1 cycle after redirect. With an outstanding miss, it arrives after the stale response plus the new response.
- o_imem_addr is stable while o_imem_req=1 and !i_imem_valid.
- Async reset assertion mid-request abandons the request. The memory side drops it on reset.

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined: an accepted redirect with i_redirect_pc[1:0]!=0 sets o_misalign=1 (sticky until reset), forces state BOOT-like idle (o_imem_req=0), and holds IF/ID at bubble.
- Undefined: i_redirect_pc[1:0] is ignored and forced to 0; o_misalign is tied to 0.

## Structure
- Shared package core_pkg: ifetch state enum, NOP_INST constant, XLEN=32.
- A single sub-module, ifetch_hold_buf, holds the one-entry capture register and its valid flag. Next-PC and FSM logic sit in ifetch.

## Test plan
- Reset release, zero-wait memory returning addr as data -> o_id_pc = 0, 4, 8 on consecutive cycles from cycle 2, o_id_valid=1.
- i_halt high 2 cycles while o_id_pc=8 -> o_id_pc stays 8, o_imem_req drops after capture (HOLD), then 12 appears the cycle after release.
- Redirect to 0x100 with 3-cycle memory latency and request outstanding -> stale word dropped, o_id_inst never shows it, o_id_pc=0x100 after the second response.
- i_data_busy and i_redirect together -> redirect ignored, o_flush=0. Redirect held after busy drops -> accepted.
- Redirect during i_halt -> pc=target, bubble into IF/ID, o_flush=1.
- With IFETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> o_misalign=1, o_imem_req=0, o_id_valid=0 thereafter.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types and constants: XLEN, the bubble instruction, fetch FSM states and the IF/ID record.
// Pure declarations; no timing or flow-control behaviour of its own.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } ifetch_state_t;

    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } ifid_t;

    function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] cur);
        return cur + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory fetch bus: request/address from fetch, valid/data back from memory.
// Response may arrive in the request cycle or any later cycle; address is held until valid.
interface ifetch_if;

    logic                     imem_req;
    logic [core_pkg::XLEN-1:0] imem_addr;
    logic                     imem_valid;
    logic [core_pkg::XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_hold_buf.sv
// One-entry capture register for a fetched word that arrived while the pipe was stalled.
// Captures in one cycle; clear has priority over capture; no backpressure of its own.
module ifetch_hold_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cap,
    input  logic            clr,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] inst,
    output logic            vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst <= NOP_INST;
            vld  <= 1'b0;
        end else if (clr) begin
            inst <= NOP_INST;
            vld  <= 1'b0;
        end else if (cap) begin
            inst <= din;
            vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Fetch stage + IF/ID register: 1 instr/cycle on zero-wait memory, first valid 2 cycles after reset.
// Holds PC/IF/ID under halt or data-busy; redirect (ignored while busy) flushes. Option: IFETCH_MISALIGN_CHECK_EN.
module ifetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_halt,
    input  logic            i_data_busy,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    ifetch_if.master        imem,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_inst,
    output logic            o_flush,
    output logic            o_misalign
);

    ifetch_state_t   state;
    ifetch_state_t   state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] stale_addr;
    logic [XLEN-1:0] target;
    ifid_t           id_q;

    logic            stall;
    logic            redir;
    logic            bad_target;
    logic            misalign;

    logic            id_load;
    logic            id_bubble;
    logic [XLEN-1:0] id_inst_src;
    logic            pc_inc;
    logic            pc_redir;
    logic            hold_cap;
    logic            hold_clr;
    logic            stale_cap;
    logic [XLEN-1:0] hold_inst;
    logic            hold_vld;

    assign stall   = i_halt | i_data_busy;
    assign o_flush = i_redirect & ~i_data_busy;
    assign redir   = o_flush & ~misalign;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign target     = i_redirect_pc;
    assign bad_target = |i_redirect_pc[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            misalign <= 1'b0;
        end else if (redir && bad_target) begin
            misalign <= 1'b1;
        end
    end
`else
    assign target     = i_redirect_pc & ~32'd3;
    assign bad_target = 1'b0;
    assign misalign   = 1'b0;
`endif

    assign o_misalign = misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: begin
                if (!misalign) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (redir) begin
                    state_nxt = imem.imem_valid ? ST_FETCH : ST_DISCARD;
                end else if (imem.imem_valid && stall) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redir || (!stall && hold_vld)) state_nxt = ST_FETCH;
            end
            ST_DISCARD: begin
                if (imem.imem_valid) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_BOOT;
        endcase
        // A bad target parks the stage idle until the next reset.
        if (redir && bad_target) state_nxt = ST_BOOT;
    end

    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        id_load        = 1'b0;
        id_bubble      = 1'b0;
        id_inst_src    = imem.imem_rdata;
        pc_inc         = 1'b0;
        pc_redir       = 1'b0;
        hold_cap       = 1'b0;
        hold_clr       = 1'b0;
        stale_cap      = 1'b0;
        case (state)
            ST_BOOT: begin
                if (redir) begin
                    pc_redir  = 1'b1;
                    id_bubble = 1'b1;
                end
            end
            ST_FETCH: begin
                imem.imem_req = 1'b1;
                if (redir) begin
                    pc_redir  = 1'b1;
                    id_bubble = 1'b1;
                    stale_cap = ~imem.imem_valid;
                end else if (imem.imem_valid && !stall) begin
                    id_load = 1'b1;
                    pc_inc  = 1'b1;
                end else if (imem.imem_valid) begin
                    hold_cap = 1'b1;
                end else if (!stall) begin
                    id_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                id_inst_src = hold_inst;
                if (redir) begin
                    hold_clr  = 1'b1;
                    pc_redir  = 1'b1;
                    id_bubble = 1'b1;
                end else if (!stall && hold_vld) begin
                    id_load  = 1'b1;
                    pc_inc   = 1'b1;
                    hold_clr = 1'b1;
                end
            end
            ST_DISCARD: begin
                // Keep presenting the abandoned address until its word comes back.
                imem.imem_req  = 1'b1;
                imem.imem_addr = stale_addr;
                if (redir) pc_redir = 1'b1;
                if (redir || !stall) id_bubble = 1'b1;
            end
            default: ;
        endcase
        if (redir && bad_target) begin
            pc_redir  = 1'b0;
            pc_inc    = 1'b0;
            id_load   = 1'b0;
            id_bubble = 1'b1;
            hold_clr  = 1'b1;
            stale_cap = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
            id_q       <= '{vld: 1'b0, pc: RESET_PC, inst: NOP_INST};
        end else begin
            if (pc_redir) begin
                pc <= target;
            end else if (pc_inc) begin
                pc <= pc_step(pc);
            end
            if (stale_cap) stale_addr <= pc;
            if (id_load) begin
                id_q <= '{vld: 1'b1, pc: pc, inst: id_inst_src};
            end else if (id_bubble) begin
                id_q.vld  <= 1'b0;
                id_q.inst <= NOP_INST;
            end
        end
    end

    ifetch_hold_buf u_hold_buf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .cap   (hold_cap),
        .clr   (hold_clr),
        .din   (imem.imem_rdata),
        .inst  (hold_inst),
        .vld   (hold_vld)
    );

    assign o_id_valid = id_q.vld;
    assign o_id_pc    = id_q.pc;
    assign o_id_inst  = id_q.inst;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a latency-programmable memory that returns the address as data.
module tb_ifetch;
    import core_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_halt = 1'b0;
    logic        i_data_busy = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_inst;
    logic        o_flush;
    logic        o_misalign;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int cnt;

    ifetch_if imem ();

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt <= 0;
        else if (imem.imem_req && !imem.imem_valid) cnt <= cnt + 1;
        else cnt <= 0;
    end

    assign imem.imem_valid = imem.imem_req && (cnt >= lat);
    assign imem.imem_rdata = imem.imem_addr;

    ifetch dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_halt        (i_halt),
        .i_data_busy   (i_data_busy),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .imem          (imem),
        .o_id_valid    (o_id_valid),
        .o_id_pc       (o_id_pc),
        .o_id_inst     (o_id_inst),
        .o_flush       (o_flush),
        .o_misalign    (o_misalign)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        checks++; if (imem.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem.imem_req); end
        checks++; if (imem.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=00000000", imem.imem_addr); end
        checks++; if (o_id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", o_id_valid); end
        checks++; if (o_id_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=00000000", o_id_pc); end
        checks++; if (o_id_inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst got=%h exp=00000013", o_id_inst); end
        checks++; if (o_misalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%b exp=0", o_misalign); end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        tick();
        checks++; if (o_id_valid !== 1'b0) begin failures++; $display("FAIL zw_cycle1_valid got=%b exp=0", o_id_valid); end
        checks++; if (imem.imem_req !== 1'b1) begin failures++; $display("FAIL zw_cycle1_req got=%b exp=1", imem.imem_req); end
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_pc = 32'(k * 4);
            checks++; if (o_id_valid !== 1'b1 || o_id_pc !== exp_pc || o_id_inst !== exp_pc) begin
                failures++; $display("FAIL zw_stream got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", o_id_valid, o_id_pc, o_id_inst, exp_pc, exp_pc);
            end
        end
    endtask

    task automatic test_halt();
        i_halt = 1'b1;
        tick();
        checks++; if (o_id_pc !== 32'h8 || imem.imem_req !== 1'b0) begin failures++; $display("FAIL halt_c1 got pc=%h req=%b exp pc=00000008 req=0", o_id_pc, imem.imem_req); end
        tick();
        checks++; if (o_id_pc !== 32'h8 || o_id_valid !== 1'b1 || imem.imem_req !== 1'b0) begin failures++; $display("FAIL halt_c2 got pc=%h v=%b req=%b exp pc=00000008 v=1 req=0", o_id_pc, o_id_valid, imem.imem_req); end
        i_halt = 1'b0;
        tick();
        checks++; if (o_id_pc !== 32'hC || o_id_inst !== 32'hC || o_id_valid !== 1'b1) begin failures++; $display("FAIL halt_release got pc=%h inst=%h v=%b exp pc=0000000c inst=0000000c v=1", o_id_pc, o_id_inst, o_id_valid); end
        checks++; if (imem.imem_addr !== 32'h10 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL halt_resume_addr got addr=%h req=%b exp addr=00000010 req=1", imem.imem_addr, imem.imem_req); end
        tick();
        checks++; if (o_id_pc !== 32'h10 || o_id_valid !== 1'b1) begin failures++; $display("FAIL halt_next got pc=%h v=%b exp pc=00000010 v=1", o_id_pc, o_id_valid); end
    endtask

    task automatic test_redirect_miss();
        int n;
        bit saw_stale;
        lat = 3;
        tick();
        checks++; if (o_id_valid !== 1'b0 || o_id_inst !== 32'h13 || o_id_pc !== 32'h10) begin failures++; $display("FAIL miss_bubble got v=%b pc=%h inst=%h exp v=0 pc=00000010 inst=00000013", o_id_valid, o_id_pc, o_id_inst); end
        i_redirect = 1'b1;
        i_redirect_pc = 32'h100;
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL miss_flush got=%b exp=1", o_flush); end
        tick();
        i_redirect = 1'b0;
        checks++; if (imem.imem_addr !== 32'h14 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL discard_addr got addr=%h req=%b exp addr=00000014 req=1", imem.imem_addr, imem.imem_req); end
        tick();
        checks++; if (imem.imem_addr !== 32'h14) begin failures++; $display("FAIL discard_addr_stable got=%h exp=00000014", imem.imem_addr); end
        n = 1;
        saw_stale = 1'b0;
        while (n < 20 && !o_id_valid) begin
            tick();
            n++;
            if (o_id_inst === 32'h14) saw_stale = 1'b1;
        end
        checks++; if (saw_stale !== 1'b0) begin failures++; $display("FAIL stale_word got seen=1 exp seen=0"); end
        checks++; if (n !== 6) begin failures++; $display("FAIL miss_latency got=%0d exp=6", n); end
        checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h100 || o_id_inst !== 32'h100) begin failures++; $display("FAIL miss_target got v=%b pc=%h inst=%h exp v=1 pc=00000100 inst=00000100", o_id_valid, o_id_pc, o_id_inst); end
        lat = 0;
    endtask

    task automatic test_busy_redirect();
        i_data_busy = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h200;
        #1;
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL busy_flush got=%b exp=0", o_flush); end
        tick();
        checks++; if (o_id_pc !== 32'h100 || o_id_valid !== 1'b1 || imem.imem_req !== 1'b0) begin failures++; $display("FAIL busy_frozen got pc=%h v=%b req=%b exp pc=00000100 v=1 req=0", o_id_pc, o_id_valid, imem.imem_req); end
        i_data_busy = 1'b0;
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL busy_drop_flush got=%b exp=1", o_flush); end
        tick();
        i_redirect = 1'b0;
        checks++; if (o_id_valid !== 1'b0 || o_id_inst !== 32'h13 || o_id_pc !== 32'h100) begin failures++; $display("FAIL busy_bubble got v=%b pc=%h inst=%h exp v=0 pc=00000100 inst=00000013", o_id_valid, o_id_pc, o_id_inst); end
        checks++; if (imem.imem_addr !== 32'h200 || imem.imem_req !== 1'b1) begin failures++; $display("FAIL busy_target_addr got addr=%h req=%b exp addr=00000200 req=1", imem.imem_addr, imem.imem_req); end
        tick();
        checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h200 || o_id_inst !== 32'h200) begin failures++; $display("FAIL busy_target got v=%b pc=%h inst=%h exp v=1 pc=00000200 inst=00000200", o_id_valid, o_id_pc, o_id_inst); end
    endtask

    task automatic test_halt_redirect();
        i_halt = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 32'h300;
        #1;
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL halt_redir_flush got=%b exp=1", o_flush); end
        tick();
        checks++; if (o_id_valid !== 1'b0 || o_id_inst !== 32'h13 || o_id_pc !== 32'h200) begin failures++; $display("FAIL halt_redir_bubble got v=%b pc=%h inst=%h exp v=0 pc=00000200 inst=00000013", o_id_valid, o_id_pc, o_id_inst); end
        checks++; if (imem.imem_addr !== 32'h300) begin failures++; $display("FAIL halt_redir_pc got=%h exp=00000300", imem.imem_addr); end
        i_halt = 1'b0;
        i_redirect = 1'b0;
        tick();
        checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h300) begin failures++; $display("FAIL halt_redir_target got v=%b pc=%h exp v=1 pc=00000300", o_id_valid, o_id_pc); end
    endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        i_redirect = 1'b1;
        i_redirect_pc = 32'h102;
        tick();
        i_redirect = 1'b0;
        checks++; if (o_misalign !== 1'b1 || imem.imem_req !== 1'b0 || o_id_valid !== 1'b0) begin failures++; $display("FAIL misalign_set got mis=%b req=%b v=%b exp mis=1 req=0 v=0", o_misalign, imem.imem_req, o_id_valid); end
        repeat (3) tick();
        checks++; if (o_misalign !== 1'b1 || imem.imem_req !== 1'b0 || o_id_valid !== 1'b0) begin failures++; $display("FAIL misalign_sticky got mis=%b req=%b v=%b exp mis=1 req=0 v=0", o_misalign, imem.imem_req, o_id_valid); end
    endtask
`else
    task automatic test_misalign();
        i_redirect = 1'b1;
        i_redirect_pc = 32'h402;
        tick();
        i_redirect = 1'b0;
        checks++; if (imem.imem_addr !== 32'h400 || o_misalign !== 1'b0 || o_id_valid !== 1'b0) begin failures++; $display("FAIL align_force got addr=%h mis=%b v=%b exp addr=00000400 mis=0 v=0", imem.imem_addr, o_misalign, o_id_valid); end
        tick();
        checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h400 || o_id_inst !== 32'h400) begin failures++; $display("FAIL align_target got v=%b pc=%h inst=%h exp v=1 pc=00000400 inst=00000400", o_id_valid, o_id_pc, o_id_inst); end
    endtask
`endif

    task automatic test_async_reset();
        lat = 3;
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (imem.imem_req !== 1'b0 || imem.imem_addr !== 32'h0) begin failures++; $display("FAIL async_rst_req got req=%b addr=%h exp req=0 addr=00000000", imem.imem_req, imem.imem_addr); end
        checks++; if (o_id_valid !== 1'b0 || o_id_inst !== 32'h13 || o_misalign !== 1'b0) begin failures++; $display("FAIL async_rst_idif got v=%b inst=%h mis=%b exp v=0 inst=00000013 mis=0", o_id_valid, o_id_inst, o_misalign); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_halt();
        test_redirect_miss();
        test_busy_redirect();
        test_halt_redirect();
        test_misalign();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
